accumulator4_sequencer: RTL

//  Instruction sequencer for the 4-bit-operand accumulator datapath. Buffers 16-bit

---
 rtl/accumulator4_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/accumulator4_sequencer.sv
// Command sequencer for the 4-bit accumulator datapath: FIFO-buffered EXEC/REPT/WAIT/CLRC
// words issued as registered datapath controls. Optional perf counter: ACC4_SEQ_PERF_EN.
module accumulator4_sequencer #(
   parameter  int unsigned FIFO_DEPTH = 8,
   localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        in_data,
   input  logic               flush,
   output logic               dp_enable,
   output logic [4:0]         dp_opcode,
   output logic [7:0]         dp_operand,
   output logic               dp_rx_carry,
   input  logic               dp_tx_carry,
   output logic               busy,
   output logic [LEVEL_W-1:0] fifo_level
`ifdef ACC4_SEQ_PERF_EN
   ,
   output logic [15:0]        perf_issued
`endif
);

   localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
   localparam logic [4:0]  OP_ADC = 5'b10001;

   typedef enum logic [1:0] {S_IDLE, S_REPT, S_WAIT} state_t;
   typedef enum logic [1:0] {K_EXEC = 2'b00, K_REPT = 2'b01, K_WAIT = 2'b10, K_CLRC = 2'b11} kind_t;

   logic [15:0]        mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LEVEL_W-1:0] level_q;
   logic               full, empty, push, pop;
   kind_t              head_kind;
   logic [4:0]         head_op;
   logic [7:0]         head_opd;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               en_q, en_d;
   logic [4:0]         op_q, op_d;
   logic [7:0]         opd_q, opd_d;
   logic               clr_q, clr_d;

   assign full      = (level_q == LEVEL_W'(FIFO_DEPTH));
   assign empty     = (level_q == '0);
   assign push      = in_valid & ~full & ~flush;
   assign pop       = (state_q == S_IDLE) & ~empty & ~flush;
   // Bit 13 is reserved and never decoded
   assign head_kind = kind_t'(mem_q[rd_ptr_q][15:14]);
   assign head_op   = mem_q[rd_ptr_q][12:8];
   assign head_opd  = mem_q[rd_ptr_q][7:0];

   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop && head_kind == K_REPT) begin
                  cnt_d = {4'b0, head_opd[3:0]};
                  if (head_opd[3:0] != 4'd0) state_d = S_REPT;
               end else if (pop && head_kind == K_WAIT) begin
                  cnt_d = head_opd;
                  if (head_opd != 8'd0) state_d = S_WAIT;
               end
            end
            S_REPT, S_WAIT: begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q <= 8'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A CLRC popped on the same edge an ADC issue ends must leave the chain cleared
   always_comb begin
      en_d  = 1'b0;
      op_d  = op_q;
      opd_d = opd_q;
      clr_d = clr_q;
      if (en_q && op_q == OP_ADC) clr_d = 1'b0;
      if (flush) begin
         clr_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  case (head_kind)
                     K_EXEC: begin
                        en_d  = 1'b1;
                        op_d  = head_op;
                        opd_d = head_opd;
                     end
                     K_REPT: begin
                        en_d  = 1'b1;
                        op_d  = head_op;
                        opd_d = 8'h00;
                     end
                     K_CLRC:  clr_d = 1'b1;
                     default: en_d  = 1'b0;
                  endcase
               end
            end
            S_REPT:  en_d = 1'b1;
            default: en_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         en_q  <= 1'b0;
         op_q  <= '0;
         opd_q <= '0;
         clr_q <= 1'b1;
      end else begin
         en_q  <= en_d;
         op_q  <= op_d;
         opd_q <= opd_d;
         clr_q <= clr_d;
      end
   end

`ifdef ACC4_SEQ_PERF_EN
   logic [15:0] perf_q;
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)   perf_q <= '0;
      else if (flush) perf_q <= '0;
      else if (en_q)  perf_q <= perf_q + 16'd1;
   end
   assign perf_issued = perf_q;
`endif

   assign in_ready    = ~full;
   assign dp_enable   = en_q;
   assign dp_opcode   = op_q;
   assign dp_operand  = opd_q;
   assign dp_rx_carry = dp_tx_carry & ~clr_q;
   assign busy        = ~empty | (state_q != S_IDLE) | en_q;
   assign fifo_level  = level_q;

endmodule
